map_ss_seq: RTL and testbench

Save-state sequencer that sits directly upstream of every mapper's save-state port. It owns `ss_act`/`ss_we`/`ss_addr`, walks the mapper's state window byte by byte, and streams the bytes out on a save or in from a valid/ready source on a load. It checks the mapper-ID byte at address 127 before any restore write is issued. It replaces ad-hoc per-mapper save/restore handling with one shared stage.

---
 rtl/map_ss_seq.sv | 203 ++++++++++++++++++++
 tb/tb_map_ss_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/map_ss_seq.sv
// map_ss_seq -- save-state sequencer placed upstream of a mapper's save-state port.
//
// Walks the mapper state window (addresses 0..SS_LEN-1) one byte at a time.
// On a save, each byte is read back from the mapper and streamed out on the
// sv_* valid/ready port. On a load, bytes are taken from the ld_* valid/ready
// port and written into the mapper, with ss_we held for WE_CYC clocks per byte.
//
// Optional feature macro: SS_IDCHK_EN
//   defined   : before a load, the mapper-ID byte at address 127 is compared with
//               MAP_NUM; a mismatch sets err and aborts with no writes issued.
//   undefined : a load starts writing immediately and err is tied low.
//
// Parameters:
//   SS_LEN   bytes per state image
//   MAP_NUM  expected mapper-ID byte at address 127
//   WE_CYC   clocks that ss_we is held per written byte
//
// Ports:
//   clk, map_rst          clock, synchronous active-high reset
//   start_save/start_load single-cycle operation requests (save has priority)
//   busy, done, err       status: active, one-cycle finish pulse, sticky ID error
//   ss_act, ss_we         mapper save-state mode and write strobe
//   ss_addr, ss_wdat      mapper state address and write byte
//   ss_rdat               mapper readback (combinational from ss_addr)
//   sv_dat/valid/ready    save stream out
//   ld_dat/valid/ready    load stream in
module map_ss_seq #(
    parameter int unsigned SS_LEN  = 128,
    parameter int unsigned MAP_NUM = 8'd27,
    parameter int unsigned WE_CYC  = 4
) (
    input  logic       clk,
    input  logic       map_rst,
    input  logic       start_save,
    input  logic       start_load,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       ss_act,
    output logic       ss_we,
    output logic [7:0] ss_addr,
    output logic [7:0] ss_wdat,
    input  logic [7:0] ss_rdat,
    output logic [7:0] sv_dat,
    output logic       sv_valid,
    input  logic       sv_ready,
    input  logic [7:0] ld_dat,
    input  logic       ld_valid,
    output logic       ld_ready
);

    localparam logic [7:0] LAST_ADDR = 8'(SS_LEN - 1);
    localparam logic [7:0] WE_LAST   = 8'(WE_CYC - 1);
    localparam logic [7:0] ID_ADDR   = 8'd127;

    if (SS_LEN == 0 || SS_LEN > 256 || WE_CYC == 0 || WE_CYC > 256 || MAP_NUM > 255) begin : g_bad_cfg
        $error("map_ss_seq: parameter out of range");
    end

    typedef enum logic [2:0] {
        IDLE,
        SV_ADDR,
        SV_OUT,
        LD_CHK0,
        LD_CHK1,
        LD_WAIT,
        LD_WR,
        DONE
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] n, n_nxt;
    logic [7:0] we_cnt, we_cnt_nxt;
    logic [7:0] wdat_q, wdat_nxt;
    logic [7:0] svdat_q, svdat_nxt;
`ifdef SS_IDCHK_EN
    logic       err_q, err_nxt;
`endif

    always_ff @(posedge clk) begin
        if (map_rst) begin
            state   <= IDLE;
            n       <= '0;
            we_cnt  <= '0;
            wdat_q  <= '0;
            svdat_q <= '0;
`ifdef SS_IDCHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            n       <= n_nxt;
            we_cnt  <= we_cnt_nxt;
            wdat_q  <= wdat_nxt;
            svdat_q <= svdat_nxt;
`ifdef SS_IDCHK_EN
            err_q   <= err_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt  = state;
        n_nxt      = n;
        we_cnt_nxt = we_cnt;
        wdat_nxt   = wdat_q;
        svdat_nxt  = svdat_q;
`ifdef SS_IDCHK_EN
        err_nxt    = err_q;
`endif
        unique case (state)
            IDLE: begin
                if (start_save) begin
                    n_nxt     = '0;
                    state_nxt = SV_ADDR;
`ifdef SS_IDCHK_EN
                    err_nxt   = 1'b0;
`endif
                end else if (start_load) begin
                    n_nxt     = '0;
`ifdef SS_IDCHK_EN
                    err_nxt   = 1'b0;
                    state_nxt = LD_CHK0;
`else
                    state_nxt = LD_WAIT;
`endif
                end
            end
            SV_ADDR: begin
                // Address has settled for a full cycle; capture the readback.
                svdat_nxt = ss_rdat;
                state_nxt = SV_OUT;
            end
            SV_OUT: begin
                if (sv_ready) begin
                    if (n == LAST_ADDR) begin
                        state_nxt = DONE;
                    end else begin
                        n_nxt     = n + 8'd1;
                        state_nxt = SV_ADDR;
                    end
                end
            end
`ifdef SS_IDCHK_EN
            LD_CHK0: state_nxt = LD_CHK1;
            LD_CHK1: begin
                if (ss_rdat != 8'(MAP_NUM)) begin
                    err_nxt   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    n_nxt     = '0;
                    state_nxt = LD_WAIT;
                end
            end
`endif
            LD_WAIT: begin
                if (ld_valid) begin
                    wdat_nxt   = ld_dat;
                    we_cnt_nxt = '0;
                    state_nxt  = LD_WR;
                end
            end
            LD_WR: begin
                if (we_cnt == WE_LAST) begin
                    if (n == LAST_ADDR) begin
                        state_nxt = DONE;
                    end else begin
                        n_nxt     = n + 8'd1;
                        state_nxt = LD_WAIT;
                    end
                end else begin
                    we_cnt_nxt = we_cnt + 8'd1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ss_addr = '0;
        case (state)
            LD_CHK0, LD_CHK1:                 ss_addr = ID_ADDR;
            SV_ADDR, SV_OUT, LD_WAIT, LD_WR:  ss_addr = n;
            default:                          ss_addr = '0;
        endcase
    end

    assign busy     = (state != IDLE) && (state != DONE);
    assign ss_act   = busy;
    assign done     = (state == DONE);
    assign ss_we    = (state == LD_WR);
    assign ld_ready = (state == LD_WAIT);
    assign sv_valid = (state == SV_OUT);
    assign ss_wdat  = wdat_q;
    assign sv_dat   = svdat_q;
`ifdef SS_IDCHK_EN
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_map_ss_seq.sv
module tb_map_ss_seq;

    localparam int SS_LEN  = 128;
    localparam int WE_CYC  = 4;
    localparam int MAP_NUM = 27;
`ifdef SS_IDCHK_EN
    localparam bit IDCHK = 1'b1;
`else
    localparam bit IDCHK = 1'b0;
`endif
    localparam int SAVE_LAT = 2 * SS_LEN + 1;
    localparam int LOAD_LAT = (IDCHK ? 2 : 0) + SS_LEN * (1 + WE_CYC) + 1;

    logic       clk = 1'b0;
    logic       map_rst, start_save, start_load;
    logic       busy, done, err, ss_act, ss_we, sv_valid, sv_ready, ld_valid, ld_ready;
    logic [7:0] ss_addr, ss_wdat, ss_rdat, sv_dat, ld_dat;

    map_ss_seq #(.SS_LEN(SS_LEN), .MAP_NUM(MAP_NUM), .WE_CYC(WE_CYC)) dut (
        .clk(clk), .map_rst(map_rst), .start_save(start_save), .start_load(start_load),
        .busy(busy), .done(done), .err(err), .ss_act(ss_act), .ss_we(ss_we),
        .ss_addr(ss_addr), .ss_wdat(ss_wdat), .ss_rdat(ss_rdat),
        .sv_dat(sv_dat), .sv_valid(sv_valid), .sv_ready(sv_ready),
        .ld_dat(ld_dat), .ld_valid(ld_valid), .ld_ready(ld_ready)
    );

    always #5 clk = ~clk;

    // Mapper model: combinational readback, write captured on the clock edge.
    logic [7:0] mem [256];
    assign ss_rdat = mem[ss_addr];
    always @(posedge clk) if (ss_we) mem[ss_addr] <= ss_wdat;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference image: what the mapper state should hold according to the ops issued.
    logic [7:0] img [SS_LEN];

    typedef struct { logic [7:0] addr; logic [7:0] dat; } wr_t;
    typedef struct { int lat; logic err; } dn_t;
    logic [7:0] exp_sv[$];
    wr_t        exp_wr[$];
    dn_t        exp_dn[$];

    int checks = 0, failures = 0;
    int t0 = 0, done_cnt = 0, sv_cnt = 0;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents an output.
    initial begin : monitor
        int run = 0;
        logic [7:0] raddr = '0, rdat = '0, prev_dat = '0;
        bit prev_stall = 0, prev_hs = 0;
        wr_t ew;
        dn_t ed;
        forever begin
            @(negedge clk);
            if (map_rst) begin
                run = 0; prev_stall = 0; prev_hs = 0;
                exp_wr.delete(); exp_sv.delete(); exp_dn.delete();
            end else begin
                if (ss_we && ld_ready) chk("we_ready_overlap", 1, 0);
                if (ss_act) chk("addr_range", int'(ss_addr < SS_LEN), 1);
                if (ss_we) begin
                    if (run == 0) begin
                        raddr = ss_addr; rdat = ss_wdat;
                    end else begin
                        chk("we_hold", {ss_addr, ss_wdat}, {raddr, rdat});
                    end
                    run++;
                end else if (run > 0) begin
                    if (exp_wr.size() == 0) chk("unexpected_write", 1, 0);
                    else begin
                        ew = exp_wr.pop_front();
                        chk("wr_addr", raddr, ew.addr);
                        chk("wr_data", rdat, ew.dat);
                        chk("we_len", run, WE_CYC);
                    end
                    run = 0;
                end
                if (sv_valid) begin
                    if (prev_stall) chk("sv_hold", sv_dat, prev_dat);
                    if (prev_hs) chk("sv_back_to_back", 1, 0);
                    if (sv_ready) begin
                        if (exp_sv.size() == 0) chk("unexpected_sv", 1, 0);
                        else chk("sv_data", sv_dat, exp_sv.pop_front());
                        sv_cnt++;
                    end
                end
                prev_stall = sv_valid && !sv_ready;
                prev_hs    = sv_valid && sv_ready;
                prev_dat   = sv_dat;
                if (done) begin
                    if (exp_dn.size() == 0) chk("unexpected_done", 1, 0);
                    else begin
                        ed = exp_dn.pop_front();
                        chk("done_err", err, ed.err);
                        if (ed.lat >= 0) chk("done_latency", cyc - t0, ed.lat);
                        chk("done_idle", {busy, ss_act}, 0);
                    end
                    done_cnt++;
                end
            end
        end
    end

    task automatic check_reset_outs();
        chk("rst_ctl", {busy, done, err, ss_act, ss_we, sv_valid, ld_ready}, 0);
        chk("rst_addr", ss_addr, 0);
        chk("rst_wdat", ss_wdat, 0);
        chk("rst_svdat", sv_dat, 0);
    endtask

    task automatic start_op(input bit s, input bit l);
        @(posedge clk); #1;
        start_save = s; start_load = l;
        @(negedge clk);
        t0 = cyc;
        chk("act_before_start", ss_act, 0);
        @(posedge clk); #1;
        start_save = 0; start_load = 0;
        @(negedge clk);
        chk("act_after_start", ss_act, 1);
        chk("err_cleared", err, 0);
    endtask

    task automatic run_save(input bit rnd, input int stall_byte, input int lat,
                            input bit both, input bit inject_load);
        int d0, base, stalled;
        for (int i = 0; i < SS_LEN; i++) exp_sv.push_back(img[i]);
        exp_dn.push_back('{lat, 1'b0});
        sv_ready = 1; d0 = done_cnt; base = sv_cnt; stalled = 0;
        start_op(1'b1, both);
        for (int k = 0; k < 4000 && done_cnt == d0; k++) begin
            @(posedge clk); #1;
            start_load = inject_load && (k == 40);
            if (stall_byte >= 0 && sv_cnt - base == stall_byte && sv_valid && stalled < 5) begin
                sv_ready = 0;
                stalled++;
                chk("stall_dat", sv_dat, img[stall_byte]);
            end else begin
                sv_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            @(negedge clk); #1;
        end
        start_load = 0; sv_ready = 1;
        if (done_cnt == d0) chk("save_timeout", 0, 1);
    endtask

    task automatic run_load(input bit rnd_data, input bit rnd_valid, input bit exp_err,
                            input int lat, input int rst_at);
        logic [7:0] d [SS_LEN];
        int d0, idx;
        bit aborted;
        for (int i = 0; i < SS_LEN; i++) d[i] = rnd_data ? 8'($urandom) : 8'(i);
        if (!exp_err) for (int i = 0; i < SS_LEN; i++) exp_wr.push_back('{8'(i), d[i]});
        exp_dn.push_back('{lat, exp_err});
        idx = 0; aborted = 0; d0 = done_cnt;
        ld_valid = 1; ld_dat = d[0];
        start_op(1'b0, 1'b1);
        if (ld_valid && ld_ready) idx++;
        for (int k = 0; k < 8000 && done_cnt == d0 && !aborted; k++) begin
            @(posedge clk); #1;
            ld_dat   = (idx < SS_LEN) ? d[idx] : 8'h00;
            ld_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (ld_valid && ld_ready) idx++;
            if (rst_at >= 0 && ss_we && int'(ss_addr) == rst_at) begin
                @(posedge clk); #1;
                map_rst = 1;
                @(posedge clk);
                @(negedge clk);
                check_reset_outs();
                @(posedge clk); #1;
                map_rst = 0; ld_valid = 0;
                aborted = 1;
            end
            #1;
        end
        ld_valid = 0;
        if (aborted) begin
            for (int i = 0; i <= rst_at; i++) img[i] = d[i];
        end else begin
            if (done_cnt == d0) chk("load_timeout", 0, 1);
            if (!exp_err) for (int i = 0; i < SS_LEN; i++) img[i] = d[i];
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        map_rst = 1; start_save = 0; start_load = 0;
        sv_ready = 1; ld_valid = 0; ld_dat = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(~i);
        for (int i = 0; i < SS_LEN; i++) img[i] = 8'(~i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outs();
        @(posedge clk); #1;
        map_rst = 0;

        // Plain save: bytes 0xFF..0x80, done 257 cycles after the start cycle.
        run_save(1'b0, -1, SAVE_LAT, 1'b0, 1'b0);
        // Save stalled for 5 cycles on byte 3.
        run_save(1'b0, 3, -1, 1'b0, 1'b0);

        // Load 0x00..0x7F with a matching ID byte.
        mem[127] = 8'(MAP_NUM); img[127] = 8'(MAP_NUM);
        run_load(1'b0, 1'b0, 1'b0, LOAD_LAT, -1);

        // Load against a wrong ID byte.
        mem[127] = 8'h2A; img[127] = 8'h2A;
        run_load(1'b1, 1'b0, IDCHK, IDCHK ? 3 : LOAD_LAT, -1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("err_sticky", err, IDCHK);

        // Simultaneous starts: save wins; a load request mid-save is ignored.
        run_save(1'b0, -1, SAVE_LAT, 1'b1, 1'b1);

        // Randomised handshakes and data.
        for (int it = 0; it < 3; it++) begin
            mem[127] = 8'(MAP_NUM); img[127] = 8'(MAP_NUM);
            run_load(1'b1, 1'b1, 1'b0, -1, -1);
            run_save(1'b1, -1, -1, 1'b0, 1'b0);
        end

        // Reset during byte 10 of a load, then a normal save.
        mem[127] = 8'(MAP_NUM); img[127] = 8'(MAP_NUM);
        run_load(1'b0, 1'b0, 1'b0, -1, 10);
        run_save(1'b0, -1, SAVE_LAT, 1'b0, 1'b0);

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("leftover_expectations", exp_sv.size() + exp_wr.size() + exp_dn.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
